// File: rtl/soc_ram_arb_pkg.sv
// Shared types and default widths for the on-chip RAM arbiter.
// The port id enum serves as the grant, round-robin state and response tag.
package soc_ram_arb_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/soc_ram_arb_rr2.sv
// Two-requester round-robin grant logic.
// The grant is combinational; last_grant remembers who was served most recently.
module soc_ram_arb_rr2
  import soc_ram_arb_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b
);

  port_id_t last_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= PORT_B;
    end else if (grant_a) begin
      last_grant <= PORT_A;
    end else if (grant_b) begin
      last_grant <= PORT_B;
    end
  end

  // On a tie the port that was not served last wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (enable) begin
      if (req_a && req_b) begin
        grant_a = (last_grant == PORT_B);
        grant_b = (last_grant == PORT_A);
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

endmodule

// File: rtl/soc_ram_arbiter.sv
// Shares the single-port on-chip RAM between the host master (A) and the audio
// fetcher (B): request mux, one-deep read response tag and contention counter.
module soc_ram_arbiter
  import soc_ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_byteenable,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [DATA_W-1:0]   a_writedata,
  output logic                a_waitrequest,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_readdatavalid,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic [DATA_W/8-1:0] b_byteenable,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [DATA_W-1:0]   b_writedata,
  output logic                b_waitrequest,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic [CNT_W-1:0]    cont_count,
  input  logic                cont_clear
);

  localparam int BE_W = DATA_W / 8;

  logic     armed;
  logic     req_a;
  logic     req_b;
  logic     grant_a;
  logic     grant_b;
  logic     tag_valid;
  port_id_t tag_id;

  assign req_a = a_read | a_write;
  assign req_b = b_read | b_write;

  // Holds off grants for the first cycle after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  soc_ram_arb_rr2 u_rr2 (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (armed),
    .req_a   (req_a),
    .req_b   (req_b),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign a_waitrequest = ~grant_a;
  assign b_waitrequest = ~grant_b;

  // Reads always fetch the full word, so byteenable only matters for writes.
  always_comb begin
    ram_chipselect = 1'b0;
    ram_address    = '0;
    ram_byteenable = '0;
    ram_write      = 1'b0;
    ram_writedata  = '0;
    if (grant_a) begin
      ram_chipselect = 1'b1;
      ram_address    = a_address;
      ram_byteenable = a_write ? a_byteenable : {BE_W{1'b1}};
      ram_write      = a_write;
      ram_writedata  = a_writedata;
    end else if (grant_b) begin
      ram_chipselect = 1'b1;
      ram_address    = b_address;
      ram_byteenable = b_write ? b_byteenable : {BE_W{1'b1}};
      ram_write      = b_write;
      ram_writedata  = b_writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid <= 1'b0;
      tag_id    <= PORT_A;
    end else begin
      tag_valid <= (grant_a & ~a_write) | (grant_b & ~b_write);
      tag_id    <= grant_b ? PORT_B : PORT_A;
    end
  end

  assign a_readdatavalid = tag_valid && (tag_id == PORT_A);
  assign b_readdatavalid = tag_valid && (tag_id == PORT_B);
  assign a_readdata      = ram_readdata;
  assign b_readdata      = ram_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cont_count <= '0;
    end else if (cont_clear) begin
      cont_count <= '0;
    end else if (armed && req_a && req_b && (cont_count != {CNT_W{1'b1}})) begin
      cont_count <= cont_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_soc_ram_arbiter.sv
// Self-checking bench for soc_ram_arbiter: directed scenarios plus random traffic,
// compared against a transaction-level model with its own memory image.
module tb_soc_ram_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] a_address, b_address;
  logic [BW-1:0] a_byteenable, b_byteenable;
  logic          a_read, a_write, b_read, b_write;
  logic [DW-1:0] a_writedata, b_writedata;
  logic          a_waitrequest, b_waitrequest;
  logic [DW-1:0] a_readdata, b_readdata;
  logic          a_readdatavalid, b_readdatavalid;
  logic [AW-1:0] ram_address;
  logic [BW-1:0] ram_byteenable;
  logic          ram_chipselect, ram_write;
  logic [DW-1:0] ram_writedata, ram_readdata;
  logic [CW-1:0] cont_count;
  logic          cont_clear;

  int checks = 0;
  int errors = 0;

  soc_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .a_address       (a_address),
    .a_byteenable    (a_byteenable),
    .a_read          (a_read),
    .a_write         (a_write),
    .a_writedata     (a_writedata),
    .a_waitrequest   (a_waitrequest),
    .a_readdata      (a_readdata),
    .a_readdatavalid (a_readdatavalid),
    .b_address       (b_address),
    .b_byteenable    (b_byteenable),
    .b_read          (b_read),
    .b_write         (b_write),
    .b_writedata     (b_writedata),
    .b_waitrequest   (b_waitrequest),
    .b_readdata      (b_readdata),
    .b_readdatavalid (b_readdatavalid),
    .ram_address     (ram_address),
    .ram_byteenable  (ram_byteenable),
    .ram_chipselect  (ram_chipselect),
    .ram_write       (ram_write),
    .ram_writedata   (ram_writedata),
    .ram_readdata    (ram_readdata),
    .cont_count      (cont_count),
    .cont_clear      (cont_clear)
  );

  always #5 clk = ~clk;

  // Environment RAM: registered address, unregistered read data, byte-masked writes.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic [AW-1:0] ram_addr_q;

  always @(posedge clk) begin
    if (ram_chipselect) begin
      ram_addr_q <= ram_address;
      if (ram_write) begin
        for (int i = 0; i < BW; i++) begin
          if (ram_byteenable[i]) ram_mem[ram_address][8*i +: 8] <= ram_writedata[8*i +: 8];
        end
      end
    end
  end

  assign ram_readdata = ram_mem[ram_addr_q];

  // Reference model state at transaction level.
  logic [DW-1:0] mdl_mem [int];
  int            m_last;
  bit            m_armed;
  bit            m_tag_valid;
  int            m_tag_port;
  logic [DW-1:0] m_tag_data;
  int            m_cnt;

  logic [AW-1:0] pool [8];

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit ar, input bit aw, input logic [AW-1:0] aa,
                               input logic [BW-1:0] abe, input logic [DW-1:0] awd,
                               input bit br, input bit bw, input logic [AW-1:0] ba,
                               input logic [BW-1:0] bbe, input logic [DW-1:0] bwd,
                               input bit clr);
    a_read = ar; a_write = aw; a_address = aa; a_byteenable = abe; a_writedata = awd;
    b_read = br; b_write = bw; b_address = ba; b_byteenable = bbe; b_writedata = bwd;
    cont_clear = clr;
  endtask

  task automatic idle();
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
  endtask

  task automatic checkOutput(input bit ga, input bit gb);
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_wd;
    bit            e_wr;
    e_addr = '0; e_be = '0; e_wd = '0; e_wr = 0;
    if (ga) begin
      e_addr = a_address; e_wr = a_write; e_wd = a_writedata;
      e_be = a_write ? a_byteenable : 4'hF;
    end else if (gb) begin
      e_addr = b_address; e_wr = b_write; e_wd = b_writedata;
      e_be = b_write ? b_byteenable : 4'hF;
    end
    chk("a_waitrequest", 32'(a_waitrequest), 32'(!ga));
    chk("b_waitrequest", 32'(b_waitrequest), 32'(!gb));
    chk("ram_chipselect", 32'(ram_chipselect), 32'(ga || gb));
    chk("ram_write", 32'(ram_write), 32'(e_wr));
    chk("ram_address", 32'(ram_address), 32'(e_addr));
    chk("ram_byteenable", 32'(ram_byteenable), 32'(e_be));
    chk("ram_writedata", ram_writedata, e_wd);
    chk("a_readdatavalid", 32'(a_readdatavalid), 32'(m_tag_valid && m_tag_port == 0));
    chk("b_readdatavalid", 32'(b_readdatavalid), 32'(m_tag_valid && m_tag_port == 1));
    if (m_tag_valid && m_tag_port == 0) chk("a_readdata", a_readdata, m_tag_data);
    if (m_tag_valid && m_tag_port == 1) chk("b_readdata", b_readdata, m_tag_data);
    chk("cont_count", 32'(cont_count), 32'(m_cnt));
  endtask

  // One clock cycle: predict, compare before the edge, then advance the model.
  task automatic cycle();
    bit want_a, want_b, ga, gb;
    int winner;
    #1;
    want_a = a_read || a_write;
    want_b = b_read || b_write;
    winner = -1;
    if (m_armed) begin
      if (want_a && want_b) winner = 1 - m_last;
      else if (want_a)      winner = 0;
      else if (want_b)      winner = 1;
    end
    ga = (winner == 0);
    gb = (winner == 1);
    checkOutput(ga, gb);
    @(posedge clk);
    m_tag_valid = 0;
    if (ga) begin
      if (a_write) mdl_mem[int'(a_address)] = merge(mdl_mem[int'(a_address)], a_writedata, a_byteenable);
      else begin m_tag_valid = 1; m_tag_port = 0; m_tag_data = mdl_mem[int'(a_address)]; end
    end else if (gb) begin
      if (b_write) mdl_mem[int'(b_address)] = merge(mdl_mem[int'(b_address)], b_writedata, b_byteenable);
      else begin m_tag_valid = 1; m_tag_port = 1; m_tag_data = mdl_mem[int'(b_address)]; end
    end
    if (winner >= 0) m_last = winner;
    if (cont_clear) m_cnt = 0;
    else if (m_armed && want_a && want_b && m_cnt < (1 << CW) - 1) m_cnt++;
    m_armed = 1;
    #1;
  endtask

  task automatic modelReset();
    m_last = 1; m_armed = 0; m_tag_valid = 0; m_tag_port = 0; m_tag_data = '0; m_cnt = 0;
  endtask

  task automatic checkResetValues();
    chk("rst_a_waitrequest", 32'(a_waitrequest), 32'd1);
    chk("rst_b_waitrequest", 32'(b_waitrequest), 32'd1);
    chk("rst_a_readdatavalid", 32'(a_readdatavalid), 32'd0);
    chk("rst_b_readdatavalid", 32'(b_readdatavalid), 32'd0);
    chk("rst_ram_chipselect", 32'(ram_chipselect), 32'd0);
    chk("rst_ram_write", 32'(ram_write), 32'd0);
    chk("rst_cont_count", 32'(cont_count), 32'd0);
  endtask

  task automatic writeA(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    applyStimulus(0, 1, addr, 4'hF, data, 0, 0, '0, '0, '0, 0);
    cycle();
  endtask

  initial begin
    int ka, kb, ia, ib;
    pool[0] = 13'h0010; pool[1] = 13'h0001; pool[2] = 13'h1FFF; pool[3] = 13'h0100;
    pool[4] = 13'h0002; pool[5] = 13'h0AAA; pool[6] = 13'h1555; pool[7] = 13'h0FFF;
    for (int i = 0; i < 8; i++) mdl_mem[int'(pool[i])] = '0;
    modelReset();
    reset_n = 1'b0;
    idle();
    #1;
    checkResetValues();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Preload every address used, with the values the scenarios rely on.
    for (int i = 0; i < 8; i++) writeA(pool[i], 32'h0);
    writeA(13'h0001, 32'h11111111);
    writeA(13'h1FFF, 32'h22222222);

    $display("[TB] single-port write then read");
    writeA(13'h0010, 32'hDEADBEEF);
    applyStimulus(1, 0, 13'h0010, 4'h0, 32'h0, 0, 0, '0, '0, '0, 0);
    cycle();
    idle();
    cycle();
    chk("t1_last_data", a_readdata, 32'hDEADBEEF);

    $display("[TB] both ports reading continuously");
    applyStimulus(1, 0, 13'h0001, 4'h0, 32'h0, 1, 0, 13'h1FFF, 4'h0, 32'h0, 0);
    for (int i = 0; i < 8; i++) cycle();
    idle();
    cycle();

    $display("[TB] byte-masked write from B");
    applyStimulus(0, 0, '0, '0, '0, 0, 1, 13'h0100, 4'h5, 32'hAABBCCDD, 0);
    cycle();
    applyStimulus(0, 0, '0, '0, '0, 1, 0, 13'h0100, 4'h0, 32'h0, 0);
    cycle();
    idle();
    cycle();
    chk("t3_byte_data", b_readdata, 32'h00BB00DD);

    $display("[TB] read and write together on A");
    applyStimulus(1, 1, 13'h0002, 4'hF, 32'h12345678, 0, 0, '0, '0, '0, 0);
    cycle();
    applyStimulus(1, 0, 13'h0002, 4'h0, 32'h0, 0, 0, '0, '0, '0, 0);
    cycle();
    idle();
    cycle();
    chk("t4_rw_data", a_readdata, 32'h12345678);

    $display("[TB] contention counter saturation and clear");
    applyStimulus(1, 0, 13'h0001, 4'h0, 32'h0, 1, 0, 13'h1FFF, 4'h0, 32'h0, 0);
    for (int i = 0; i < 20; i++) cycle();
    chk("t5_saturated", 32'(cont_count), 32'hF);
    applyStimulus(1, 0, 13'h0001, 4'h0, 32'h0, 1, 0, 13'h1FFF, 4'h0, 32'h0, 1);
    cycle();
    chk("t5_cleared", 32'(cont_count), 32'h0);
    idle();
    cycle();

    $display("[TB] reset during a pending B read");
    applyStimulus(0, 0, '0, '0, '0, 1, 0, 13'h1FFF, 4'h0, 32'h0, 0);
    cycle();
    idle();
    #1;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkResetValues();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      ka = $urandom_range(0, 3);
      kb = $urandom_range(0, 3);
      ia = $urandom_range(0, 7);
      ib = $urandom_range(0, 7);
      applyStimulus(ka == 1 || ka == 3, ka >= 2, pool[ia], 4'($urandom_range(0, 15)), $urandom,
                    kb == 1 || kb == 3, kb >= 2, pool[ib], 4'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 15) == 0);
      cycle();
    end
    idle();
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
